multiword_add_sequencer: RTL and testbench

//  Multi-cycle wide adder controller. Captures two WIDTH-bit operands and sequences one shared
//  32-bit carry-select adder slice over WIDTH/32 words, LSW first. Word carry is chained through
//  a carry register. Sits between an operand producer and a result consumer.

---
 rtl/multiword_add_sequencer_pkg.sv | 19 +
 rtl/multiword_add_sequencer_csa.sv | 40 ++++
 rtl/multiword_add_sequencer.sv | 127 ++++++++++++
 tb/tb_multiword_add_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multiword_add_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addseq_pkg
//  Description : Shared types and constants for the multi-word add sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package addseq_pkg;

    // Width of the shared adder slice; the operand is processed in words of this size.
    localparam int SLICE_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addseq_state_e;

endpackage : addseq_pkg
`default_nettype wire

// File: rtl/multiword_add_sequencer_csa.sv
`default_nettype none
// ============================================================================
//  Module      : carry_select_adder_56678_32bits
//  Description : Combinational 32-bit carry-select adder. Each 8-bit block
//                precomputes its sum for carry-in 0 and 1; the incoming
//                block carry picks one.
//  Revision    : 1.0  initial release
// ============================================================================
module carry_select_adder_56678_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    localparam int BLK_W = 8;
    localparam int NBLK  = 32 / BLK_W;

    logic [NBLK:0] blk_c;

    assign blk_c[0] = cin;

    generate
        for (genvar i = 0; i < NBLK; i++) begin : g_blk
            logic [BLK_W:0] s0;
            logic [BLK_W:0] s1;

            // Both candidate sums are formed in parallel; the chain only muxes.
            assign s0 = {1'b0, a[i*BLK_W +: BLK_W]} + {1'b0, b[i*BLK_W +: BLK_W]};
            assign s1 = {1'b0, a[i*BLK_W +: BLK_W]} + {1'b0, b[i*BLK_W +: BLK_W]}
                      + {{BLK_W{1'b0}}, 1'b1};
            assign {blk_c[i+1], sum[i*BLK_W +: BLK_W]} = blk_c[i] ? s1 : s0;
        end
    endgenerate

    assign cout = blk_c[NBLK];

endmodule : carry_select_adder_56678_32bits
`default_nettype wire

// File: rtl/multiword_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : multiword_add_sequencer
//  Description : Multi-cycle WIDTH-bit adder. Operands are captured on an
//                input handshake, then one shared 32-bit slice is stepped
//                over the words LSW first with the carry chained through a
//                register. The result is held until the consumer accepts it.
//  Config      : ADDSEQ_SUB_EN - adds in_sub; when set the block computes
//                a - b (out_cout=1 means no borrow).
//  Revision    : 1.0  initial release
// ============================================================================
module multiword_add_sequencer
    import addseq_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
`ifdef ADDSEQ_SUB_EN
    ,
    input  logic             in_sub
`endif
);

    // Word count is derived from WIDTH and is intentionally not overridable.
    localparam int WORDS = WIDTH / SLICE_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    addseq_state_e                     state;
    logic [IDX_W-1:0]                  idx;
    logic                              carry;
    logic [WORDS-1:0][SLICE_W-1:0]     a_q;
    logic [WORDS-1:0][SLICE_W-1:0]     b_q;
    logic [WORDS-1:0][SLICE_W-1:0]     sum_q;
    logic [SLICE_W-1:0]                slice_sum;
    logic                              slice_cout;
    logic [WIDTH-1:0]                  b_load;
    logic                              carry_load;

    // Operand B and initial carry as seen at the accept edge.
`ifdef ADDSEQ_SUB_EN
    assign b_load     = in_sub ? ~in_b : in_b;
    assign carry_load = in_sub ? 1'b1  : in_cin;
`else
    assign b_load     = in_b;
    assign carry_load = in_cin;
`endif

    carry_select_adder_56678_32bits u_slice (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign out_sum = sum_q;

    // Control FSM; all handshake and status outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= b_load;
                        carry    <= carry_load;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx] <= slice_sum;
                    carry      <= slice_cout;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        out_cout  <= slice_cout;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule : multiword_add_sequencer
`default_nettype wire

// File: tb/tb_multiword_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiword_add_sequencer
//  Description : Scoreboard bench for multiword_add_sequencer at WIDTH=128
//                and WIDTH=32.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multiword_add_sequencer;

    localparam int W   = 128;
    localparam int W32 = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
    logic [W-1:0]    in_a, in_b, out_sum;
    logic            in_valid32, in_ready32, in_cin32, out_valid32, out_ready32, out_cout32, busy32;
    logic [W32-1:0]  in_a32, in_b32, out_sum32;
`ifdef ADDSEQ_SUB_EN
    logic            in_sub, in_sub32;
`endif

    int              n_vec = 0;
    int              n_err = 0;
    logic            auto_rdy = 1'b0;
    logic [W:0]      sb_q[$];
    logic [W32:0]    sb32_q[$];

    always #5 clk = ~clk;

    multiword_add_sequencer #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
`ifdef ADDSEQ_SUB_EN
        , .in_sub(in_sub)
`endif
    );

    multiword_add_sequencer #(.WIDTH(W32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .in_a(in_a32), .in_b(in_b32), .in_cin(in_cin32), .out_valid(out_valid32),
        .out_ready(out_ready32), .out_sum(out_sum32), .out_cout(out_cout32), .busy(busy32)
`ifdef ADDSEQ_SUB_EN
        , .in_sub(in_sub32)
`endif
    );

    task automatic check_eq(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    endfunction

    // Present one operation, wait for the accept edge, then log its expected result.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W:0] exp);
        int t = 0;
        in_a = a; in_b = b; in_cin = cin;
`ifdef ADDSEQ_SUB_EN
        in_sub = sub;
`endif
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", {{W{1'b0}}, in_ready}, (W+1)'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb_q.push_back(exp);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send32(input logic [W32-1:0] a, input logic [W32-1:0] b, input logic cin);
        int t = 0;
        in_a32 = a; in_b32 = b; in_cin32 = cin; in_valid32 = 1'b1;
        while (!in_ready32 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready32) begin
            check_eq("accept32_timeout", {{W{1'b0}}, in_ready32}, (W+1)'(1));
            in_valid32 = 1'b0;
            return;
        end
        @(posedge clk);
        sb32_q.push_back({1'b0, a} + {1'b0, b} + (W32+1)'(cin));
        #1;
        in_valid32 = 1'b0;
    endtask

    task automatic drain;
        int t = 0;
        while ((sb_q.size() != 0 || sb32_q.size() != 0) && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        check_eq("drain", (W+1)'(sb_q.size() + sb32_q.size()), '0);
    endtask

    // Result monitors: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) check_eq("sb_empty", '0, (W+1)'(1));
            else check_eq("result128", {out_cout, out_sum}, sb_q.pop_front());
        end
        if (rst_n && out_valid32 && out_ready32) begin
            if (sb32_q.size() == 0) check_eq("sb32_empty", '0, (W+1)'(1));
            else check_eq("result32", (W+1)'({out_cout32, out_sum32}), (W+1)'(sb32_q.pop_front()));
        end
    end

    // Random consumer back-pressure.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (auto_rdy) begin
                out_ready   = ($urandom_range(0, 3) != 0);
                out_ready32 = ($urandom_range(0, 2) != 0);
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb, held;
        logic         rc, rs;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_cin = 1'b0;
        in_a = '0; in_b = '0;
        in_valid32 = 1'b0; out_ready32 = 1'b0; in_cin32 = 1'b0; in_a32 = '0; in_b32 = '0;
`ifdef ADDSEQ_SUB_EN
        in_sub = 1'b0; in_sub32 = 1'b0;
`endif
        rs = 1'b0;
        #12;
        check_eq("rst_out_valid", (W+1)'(out_valid), '0);
        check_eq("rst_sum", {out_cout, out_sum}, '0);
        check_eq("rst_busy", (W+1)'(busy), '0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_in_ready", (W+1)'(in_ready), (W+1)'(1));

        // All-ones plus one: wraps to zero with carry out, 4-edge latency.
        send({W{1'b1}}, (W)'(1), 1'b0, 1'b0, {1'b1, {W{1'b0}}});
        repeat (3) begin @(posedge clk); #1; end
        check_eq("lat_k3_valid", (W+1)'(out_valid), '0);
        check_eq("lat_k3_busy", (W+1)'(busy), (W+1)'(1));
        @(posedge clk); #1;
        check_eq("lat_k4_valid", (W+1)'(out_valid), (W+1)'(1));
        check_eq("lat_k4_sum", {out_cout, out_sum}, {1'b1, {W{1'b0}}});

        // Result is held under consumer stall; new requests are ignored.
        held = out_sum;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; in_a = W'(i + 3); in_b = W'(i * 7);
            @(posedge clk); #1;
            check_eq("hold_valid", (W+1)'(out_valid), (W+1)'(1));
            check_eq("hold_sum", {1'b0, out_sum}, {1'b0, held});
            check_eq("hold_in_ready", (W+1)'(in_ready), '0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("release_valid", (W+1)'(out_valid), '0);
        check_eq("release_in_ready", (W+1)'(in_ready), (W+1)'(1));
        check_eq("release_sb", (W+1)'(sb_q.size()), '0);

        // Word-wise carries plus carry-in.
        send(128'h00000001_00000002_00000003_00000004, 128'h10000000_20000000_30000000_40000000,
             1'b1, 1'b0, {1'b0, 128'h10000001_20000002_30000003_40000005});
        out_ready = 1'b1;
        drain();
        out_ready = 1'b0;

        // Reset on the second RUN edge aborts the operation.
        send({W{1'b1}}, {W{1'b1}}, 1'b1, 1'b0, {1'b1, {W{1'b1}}});
        @(posedge clk); #1;
        check_eq("abort_busy", (W+1)'(busy), (W+1)'(1));
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_sum", {out_cout, out_sum}, '0);
        check_eq("abort_valid", (W+1)'({busy, out_valid}), '0);
        void'(sb_q.pop_back());
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_in_ready", (W+1)'(in_ready), (W+1)'(1));
        send(128'h89ABCDEF_01234567_FFFFFFFF_80000000, 128'h76543210_FEDCBA98_00000001_80000000,
             1'b0, 1'b0, {1'b1, 128'h00000000_00000000_00000001_00000000});
        out_ready = 1'b1;
        drain();
        out_ready = 1'b0;

`ifdef ADDSEQ_SUB_EN
        send(W'(5), W'(7), 1'b1, 1'b1, {1'b0, {(W-1){1'b1}}, 1'b0});
        out_ready = 1'b1;
        drain();
        send(W'(7), W'(5), 1'b0, 1'b1, {1'b1, W'(2)});
        drain();
        out_ready = 1'b0;
`endif

        // Random traffic with consumer stalls.
        auto_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom(), $urandom(), $urandom(), $urandom()};
            rb = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (i % 8 == 0) ra = {W{1'b1}};
            rc = 1'(($urandom() & 1) != 0);
`ifdef ADDSEQ_SUB_EN
            rs = 1'(($urandom() & 1) != 0);
`endif
            send(ra, rb, rc, rs, ref_add(ra, rb, rc, rs));
            if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
        end
        drain();

        // Single-word configuration.
        for (int i = 0; i < 300; i++) begin
            send32((i % 5 == 0) ? 32'hFFFF_FFFF : $urandom(), $urandom(), 1'(($urandom() & 1) != 0));
        end
        drain();
        auto_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_multiword_add_sequencer
`default_nettype wire
